// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus per-key stable-level debouncer for active-low push keys.
// Optional toggle outputs are built only when KEY_DEBOUNCER_TOGGLE_EN is defined.
module key_debouncer #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n_raw,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_released,
  output logic [N_KEYS-1:0] key_toggle
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] sync_2;
  logic [N_KEYS-1:0] sync;
  logic [CNT_W-1:0]  cnt [N_KEYS];

  // Synchronizer resets to all-ones so a key held through reset reads as released.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= key_n_raw;
      sync_2 <= sync_1;
    end
  end

  assign sync = ~sync_2;

  // NOTE: the counter array is small and explicitly reset, so an abandoned count never leaks past reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
      key_down     <= '0;
      key_pressed  <= '0;
      key_released <= '0;
    end else begin
      key_pressed  <= '0;
      key_released <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync[i] == key_down[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          key_down[i]     <= sync[i];
          cnt[i]          <= '0;
          key_pressed[i]  <= sync[i];
          key_released[i] <= ~sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic [N_KEYS-1:0] toggle_q;

  always_ff @(posedge clk) begin
    if (rst) toggle_q <= '0;
    else     toggle_q <= toggle_q ^ key_pressed;
  end

  assign key_toggle = toggle_q;
`else
  assign key_toggle = '0;
`endif

endmodule
